// File: rtl/pipo_univ_shift.sv
// pipo_univ_shift: WIDTH-generic parallel-in/parallel-out register with
// hold/load/shift/rotate/arithmetic-shift/clear modes, serial in/out and a
// multi-cycle burst-shift engine with busy/done handshake.
// Optional feature macro: PIPO_PARITY_EN (adds in_par, parity, par_err).
module pipo_univ_shift #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [WIDTH-1:0] in,
    input  logic             sin_l,
    input  logic             sin_r,
`ifdef PIPO_PARITY_EN
    input  logic             in_par,
    output logic             parity,
    output logic             par_err,
`endif
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROTL = 3'd4;
    localparam logic [2:0] MODE_ROTR = 3'd5;
    localparam logic [2:0] MODE_ASR  = 3'd6;
    localparam logic [2:0] MODE_CLR  = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] Q_ZERO   = {WIDTH{1'b0}};

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // One application of an operation to the register contents.
    function automatic logic [WIDTH-1:0] step_f(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] d,
        input logic [WIDTH-1:0] ld,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] r;
        case (op)
            MODE_HOLD: r = d;
            MODE_LOAD: r = ld;
            MODE_SHL:  r = {d[WIDTH-2:0], sl};
            MODE_SHR:  r = {sr, d[WIDTH-1:1]};
            MODE_ROTL: r = {d[WIDTH-2:0], d[WIDTH-1]};
            MODE_ROTR: r = {d[0], d[WIDTH-1:1]};
            MODE_ASR:  r = {d[WIDTH-1], d[WIDTH-1:1]};
            MODE_CLR:  r = Q_ZERO;
            default:   r = d;
        endcase
        return r;
    endfunction

    // Shift-class modes are the only ones that can run as a burst.
    function automatic logic is_shift_f(input logic [2:0] op);
        return (op >= MODE_SHL) && (op <= MODE_ASR);
    endfunction

    // Even parity over a data word.
    function automatic logic parity_f(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] q_r, q_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [2:0]       op_r, op_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;
`ifdef PIPO_PARITY_EN
    logic             par_err_r, par_err_nxt_s;
`endif

    // Next-state decode: single steps in IDLE, latched op repeated in BURST.
    always_comb begin
        q_nxt_s     = q_r;
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        op_nxt_s    = op_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
`ifdef PIPO_PARITY_EN
        par_err_nxt_s = 1'b0;
`endif
        if (en) begin
            case (state_r)
                IDLE: begin
                    if (start && is_shift_f(mode)) begin
                        if (burst_len == CNT_ZERO) begin
                            // Empty burst: complete immediately, data untouched.
                            done_nxt_s = 1'b1;
                        end else begin
                            q_nxt_s   = step_f(mode, q_r, in, sin_l, sin_r);
                            op_nxt_s  = mode;
                            cnt_nxt_s = burst_len - CNT_ONE;
                            if (burst_len == CNT_ONE) begin
                                done_nxt_s = 1'b1;
                            end else begin
                                state_nxt_s = BURST;
                                busy_nxt_s  = 1'b1;
                            end
                        end
                    end else begin
                        q_nxt_s = step_f(mode, q_r, in, sin_l, sin_r);
`ifdef PIPO_PARITY_EN
                        if (mode == MODE_LOAD) begin
                            par_err_nxt_s = parity_f(in) ^ in_par;
                        end else begin
                            par_err_nxt_s = 1'b0;
                        end
`endif
                    end
                end
                BURST: begin
                    q_nxt_s   = step_f(op_r, q_r, in, sin_l, sin_r);
                    cnt_nxt_s = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = IDLE;
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = BURST;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    busy_nxt_s  = 1'b0;
                end
            endcase
        end else begin
            // Clock enable low: everything except the done pulse holds.
            state_nxt_s = state_r;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            q_r     <= Q_ZERO;
            cnt_r   <= CNT_ZERO;
            op_r    <= MODE_HOLD;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef PIPO_PARITY_EN
            par_err_r <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            q_r     <= q_nxt_s;
            cnt_r   <= cnt_nxt_s;
            op_r    <= op_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
`ifdef PIPO_PARITY_EN
            par_err_r <= par_err_nxt_s;
`endif
        end
    end

    assign q      = q_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign sout_l = q_r[WIDTH-1];
    assign sout_r = q_r[0];
`ifdef PIPO_PARITY_EN
    assign parity  = parity_f(q_r);
    assign par_err = par_err_r;
`endif

endmodule

// File: tb/tb_pipo_univ_shift.sv
// Self-checking bench for pipo_univ_shift: a table of per-cycle vectors with
// hand-derived expected results, fed through an expected-value queue, plus a
// hand-written reset-during-burst sequence.
module tb_pipo_univ_shift;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic       start;
    logic [3:0] burst_len;
    logic [7:0] in;
    logic       sin_l;
    logic       sin_r;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic       busy;
    logic       done;
`ifdef PIPO_PARITY_EN
    logic       in_par;
    logic       parity;
    logic       par_err;
`endif

    pipo_univ_shift #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .start     (start),
        .burst_len (burst_len),
        .in        (in),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
`ifdef PIPO_PARITY_EN
        .in_par    (in_par),
        .parity    (parity),
        .par_err   (par_err),
`endif
        .q         (q),
        .sout_l    (sout_l),
        .sout_r    (sout_r),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] mode;
        logic       start;
        logic [3:0] bl;
        logic [7:0] din;
        logic       sl;
        logic       sr;
        logic [7:0] eq;
        logic       eb;
        logic       ed;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic       b;
        logic       d;
        logic       pe;
        int         idx;
    } exp_t;

    vec_t tv[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mkv(logic e, logic [2:0] m, logic s, logic [3:0] bl,
                                 logic [7:0] d, logic sl, logic sr,
                                 logic [7:0] eq, logic eb, logic ed);
        vec_t v;
        v.en = e; v.mode = m; v.start = s; v.bl = bl; v.din = d;
        v.sl = sl; v.sr = sr; v.eq = eq; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, required %h", name, idx, act, req);
        end
    endtask

    // Pop the oldest expectation and compare against the DUT outputs now.
    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: queue empty, got q=%h, required an entry", q);
        end else begin
            e = sb.pop_front();
            chk("q",      e.idx, q,             e.q);
            chk("busy",   e.idx, {7'd0, busy},   {7'd0, e.b});
            chk("done",   e.idx, {7'd0, done},   {7'd0, e.d});
            chk("sout_l", e.idx, {7'd0, sout_l}, {7'd0, e.q[7]});
            chk("sout_r", e.idx, {7'd0, sout_r}, {7'd0, e.q[0]});
`ifdef PIPO_PARITY_EN
            chk("parity",  e.idx, {7'd0, parity},  {7'd0, ^e.q});
            chk("par_err", e.idx, {7'd0, par_err}, {7'd0, e.pe});
`endif
        end
    endtask

    task automatic push_exp(input logic [7:0] eq, input logic eb, input logic ed,
                            input logic pe, input int idx);
        exp_t e;
        e.q = eq; e.b = eb; e.d = ed; e.pe = pe; e.idx = idx;
        sb.push_back(e);
    endtask

    // Drive one vector, let one active edge pass, then compare.
    task automatic apply(input vec_t v, input int idx);
        en = v.en; mode = v.mode; start = v.start; burst_len = v.bl;
        in = v.din; sin_l = v.sl; sin_r = v.sr;
`ifdef PIPO_PARITY_EN
        in_par = ^v.din;
`endif
        push_exp(v.eq, v.eb, v.ed, 1'b0, idx);
        @(posedge clk);
        #1;
        check_out();
    endtask

    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3;
    localparam logic [2:0] ROTL = 3'd4, ROTR = 3'd5, ASR = 3'd6, CLR = 3'd7;

    initial begin
        rst = 1'b1; en = 1'b0; mode = HOLD; start = 1'b0; burst_len = 4'd0;
        in = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
`ifdef PIPO_PARITY_EN
        in_par = 1'b0;
`endif

        //        en    mode  st    bl     in     sl    sr    q      busy  done
        // basic modes
        tv.push_back(mkv(1'b1, LOAD, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0));
        tv.push_back(mkv(1'b1, SHL,  1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 8'h4B, 1'b0, 1'b0));
        tv.push_back(mkv(1'b1, SHR,  1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h25, 1'b0, 1'b0));
        tv.push_back(mkv(1'b1, LOAD, 1'b0, 4'd0, 8'h96, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0));
        tv.push_back(mkv(1'b1, ASR,  1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'hCB, 1'b0, 1'b0));
        tv.push_back(mkv(1'b0, LOAD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'hCB, 1'b0, 1'b0));
        tv.push_back(mkv(1'b1, ROTR, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'hE5, 1'b0, 1'b0));
        tv.push_back(mkv(1'b1, ROTL, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'hCB, 1'b0, 1'b0));
        tv.push_back(mkv(1'b1, HOLD, 1'b0, 4'd0, 8'hFF, 1'b0, 1'b0, 8'hCB, 1'b0, 1'b0));
        // ROTL burst of 3, inputs ignored while busy
        tv.push_back(mkv(1'b1, LOAD, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0));
        tv.push_back(mkv(1'b1, ROTL, 1'b1, 4'd3, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0));
        tv.push_back(mkv(1'b1, LOAD, 1'b1, 4'd7, 8'hFF, 1'b0, 1'b0, 8'h06, 1'b1, 1'b0));
        tv.push_back(mkv(1'b1, CLR,  1'b0, 4'd0, 8'hFF, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b1));
        tv.push_back(mkv(1'b1, HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0));
        // same burst with a two-cycle en stall
        tv.push_back(mkv(1'b1, LOAD, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0));
        tv.push_back(mkv(1'b1, ROTL, 1'b1, 4'd3, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0));
        tv.push_back(mkv(1'b0, CLR,  1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0));
        tv.push_back(mkv(1'b0, HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0));
        tv.push_back(mkv(1'b1, HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h06, 1'b1, 1'b0));
        tv.push_back(mkv(1'b1, HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b1));
        tv.push_back(mkv(1'b1, HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0));
        // burst_len 1, then done clears with en low
        tv.push_back(mkv(1'b1, SHR,  1'b1, 4'd1, 8'h00, 1'b0, 1'b1, 8'h86, 1'b0, 1'b1));
        tv.push_back(mkv(1'b0, HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h86, 1'b0, 1'b0));
        // burst_len 0, non-shift start, clear
        tv.push_back(mkv(1'b1, LOAD, 1'b0, 4'd0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0));
        tv.push_back(mkv(1'b1, SHL,  1'b1, 4'd0, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1));
        tv.push_back(mkv(1'b1, HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0));
        tv.push_back(mkv(1'b1, LOAD, 1'b1, 4'd4, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0));
        tv.push_back(mkv(1'b1, CLR,  1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
        // serial stream fed through a 4-step SHL burst
        tv.push_back(mkv(1'b1, SHL,  1'b1, 4'd4, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0));
        tv.push_back(mkv(1'b1, HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0));
        tv.push_back(mkv(1'b1, HOLD, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0));
        tv.push_back(mkv(1'b1, HOLD, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 8'h0B, 1'b0, 1'b1));
        // ASR with a clear MSB
        tv.push_back(mkv(1'b1, LOAD, 1'b0, 4'd0, 8'h40, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0));
        tv.push_back(mkv(1'b1, ASR,  1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0));

        // reset state
        #12;
        push_exp(8'h00, 1'b0, 1'b0, 1'b0, -1);
        check_out();
        rst = 1'b0;

        foreach (tv[i]) apply(tv[i], i);

`ifdef PIPO_PARITY_EN
        // LOAD with wrong parity flag raises par_err for one cycle
        en = 1'b1; mode = LOAD; start = 1'b0; in = 8'hA5; in_par = 1'b1;
        push_exp(8'hA5, 1'b0, 1'b0, 1'b1, 100);
        @(posedge clk);
        #1;
        check_out();
        apply(mkv(1'b1, HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0), 101);
`endif

        // reset asserted one cycle into a 5-step SHR burst
        apply(mkv(1'b1, LOAD, 1'b0, 4'd0, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0), 200);
        apply(mkv(1'b1, SHR,  1'b1, 4'd5, 8'h00, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b0), 201);
        #3;
        rst = 1'b1;
        #1;
        push_exp(8'h00, 1'b0, 1'b0, 1'b0, 202);
        check_out();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            apply(mkv(1'b1, HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0), 210 + k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
